// File: rtl/gauss_win_linebuf_ctrl.sv
// Line-buffer controller and 3-row window sequencer for the 3x3 Gaussian blur.
// Ping-pong line RAMs, priming FSM, position tracking and sticky overflow flag.
module gauss_win_linebuf_ctrl #(
    parameter int COLORDEPTH = 8,
    parameter int M_DEPTH    = 3,
    parameter int MAX_WIDTH  = 2048,
    parameter int ADDR_W     = 11,
    parameter int LINE_W     = 12
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 en_i,
    input  logic [COLORDEPTH-1:0]                px_i,
    input  logic                                 dv_i,
    input  logic                                 hs_i,
    input  logic                                 vs_i,
    output logic [M_DEPTH-1:0][COLORDEPTH-1:0]   vect_o,
    output logic                                 dv_o,
    output logic                                 hs_o,
    output logic                                 vs_o,
    output logic [ADDR_W-1:0]                    col_o,
    output logic [LINE_W-1:0]                    line_o,
    output logic [1:0]                           state_o,
    output logic                                 ovf_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRIME = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] COL_LAST = ADDR_W'(MAX_WIDTH - 1);
    localparam logic [ADDR_W-1:0] COL_ONE  = ADDR_W'(1);
    localparam logic [LINE_W-1:0] LINE_ONE = LINE_W'(1);

    logic [COLORDEPTH-1:0] mem_a [0:MAX_WIDTH-1];
    logic [COLORDEPTH-1:0] mem_b [0:MAX_WIDTH-1];

    state_t                state_q, state_d;
    logic                  vs_q, vs_d;
    logic                  dv_q, dv_d;
    logic                  hs_q, hs_d;
    logic                  dvo_q, dvo_d;
    logic [ADDR_W-1:0]     col_q, col_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic                  sel_q, sel_d;
    logic                  full_q, full_d;
    logic                  ovf_q, ovf_d;
    logic [COLORDEPTH-1:0] px_q, px_d;
    logic [COLORDEPTH-1:0] rd_a_q, rd_a_d;
    logic [COLORDEPTH-1:0] rd_b_q, rd_b_d;
    logic                  rsel_q, rsel_d;
    logic [ADDR_W-1:0]     colo_q, colo_d;
    logic [LINE_W-1:0]     lineo_q, lineo_d;

    logic                  fs;
    logic                  le;
    logic [ADDR_W-1:0]     pcol;
    logic [LINE_W-1:0]     pline;
    logic                  psel;
    logic                  pfull;
    logic                  wr_en;

    // Frame start beats line end; a pixel arriving with frame start is line 0, col 0.
    assign fs    = vs_i & ~vs_q;
    assign le    = ~dv_i & dv_q;
    assign pcol  = fs ? '0 : col_q;
    assign pline = fs ? '0 : line_q;
    assign psel  = fs ? 1'b0 : sel_q;
    assign pfull = fs ? 1'b0 : full_q;
    assign wr_en = dv_i & ~pfull;

    // Next-state: FSM, position counters, bank select, RAM read capture.
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        line_d  = line_q;
        sel_d   = sel_q;
        full_d  = full_q;
        ovf_d   = ovf_q;
        px_d    = px_q;
        rd_a_d  = rd_a_q;
        rd_b_d  = rd_b_q;
        rsel_d  = rsel_q;
        colo_d  = colo_q;
        lineo_d = lineo_q;
        vs_d    = vs_i;
        dv_d    = dv_i;
        hs_d    = hs_i;
        if (fs) begin
            state_d = en_i ? PRIME : IDLE;
            col_d   = '0;
            line_d  = '0;
            sel_d   = 1'b0;
            full_d  = 1'b0;
            ovf_d   = 1'b0;
            colo_d  = '0;
            lineo_d = '0;
        end else if (le) begin
            col_d  = '0;
            full_d = 1'b0;
            sel_d  = ~sel_q;
            if (line_q != '1) begin
                line_d = line_q + LINE_ONE;
            end
            if (state_q == PRIME && line_q == LINE_ONE) begin
                state_d = RUN;
            end
        end
        if (dv_i) begin
            px_d    = px_i;
            rd_a_d  = mem_a[pcol];
            rd_b_d  = mem_b[pcol];
            rsel_d  = psel;
            colo_d  = pcol;
            lineo_d = pline;
            if (pfull) begin
                ovf_d = 1'b1;
            end else if (pcol == COL_LAST) begin
                full_d = 1'b1;
                col_d  = pcol;
            end else begin
                col_d = pcol + COL_ONE;
            end
        end
        dvo_d = dv_i & (state_d == RUN);
    end

    // Control and output registers, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            vs_q    <= 1'b0;
            dv_q    <= 1'b0;
            hs_q    <= 1'b0;
            dvo_q   <= 1'b0;
            col_q   <= '0;
            line_q  <= '0;
            sel_q   <= 1'b0;
            full_q  <= 1'b0;
            ovf_q   <= 1'b0;
            px_q    <= '0;
            rd_a_q  <= '0;
            rd_b_q  <= '0;
            rsel_q  <= 1'b0;
            colo_q  <= '0;
            lineo_q <= '0;
        end else begin
            state_q <= state_d;
            vs_q    <= vs_d;
            dv_q    <= dv_d;
            hs_q    <= hs_d;
            dvo_q   <= dvo_d;
            col_q   <= col_d;
            line_q  <= line_d;
            sel_q   <= sel_d;
            full_q  <= full_d;
            ovf_q   <= ovf_d;
            px_q    <= px_d;
            rd_a_q  <= rd_a_d;
            rd_b_q  <= rd_b_d;
            rsel_q  <= rsel_d;
            colo_q  <= colo_d;
            lineo_q <= lineo_d;
        end
    end

    // Line RAM write: the pixel overwrites the bank that holds line r-2.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (psel) begin
                mem_a[pcol] <= px_i;
            end else begin
                mem_b[pcol] <= px_i;
            end
        end
    end

    assign vect_o[0] = px_q;
    assign vect_o[1] = rsel_q ? rd_b_q : rd_a_q;
    assign vect_o[2] = rsel_q ? rd_a_q : rd_b_q;
    assign dv_o      = dvo_q;
    assign hs_o      = hs_q;
    assign vs_o      = vs_q;
    assign col_o     = colo_q;
    assign line_o    = lineo_q;
    assign state_o   = state_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_gauss_win_linebuf_ctrl.sv
// Bench for gauss_win_linebuf_ctrl: per-frame line/column pixel table model,
// scripted priming/restart/overflow/reset scenarios, then random frames.
module tb_gauss_win_linebuf_ctrl;

    localparam int CD   = 8;
    localparam int MAXW = 16;
    localparam int AW   = 4;
    localparam int LW   = 12;
    localparam int NL   = 64;
    localparam int LMAX = (1 << LW) - 1;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              en_i = 1'b0;
    logic [CD-1:0]     px_i = '0;
    logic              dv_i = 1'b0;
    logic              hs_i = 1'b0;
    logic              vs_i = 1'b0;
    logic [2:0][CD-1:0] vect_o;
    logic              dv_o;
    logic              hs_o;
    logic              vs_o;
    logic [AW-1:0]     col_o;
    logic [LW-1:0]     line_o;
    logic [1:0]        state_o;
    logic              ovf_o;

    gauss_win_linebuf_ctrl #(
        .COLORDEPTH(CD),
        .M_DEPTH   (3),
        .MAX_WIDTH (MAXW),
        .ADDR_W    (AW),
        .LINE_W    (LW)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en_i   (en_i),
        .px_i   (px_i),
        .dv_i   (dv_i),
        .hs_i   (hs_i),
        .vs_i   (vs_i),
        .vect_o (vect_o),
        .dv_o   (dv_o),
        .hs_o   (hs_o),
        .vs_o   (vs_o),
        .col_o  (col_o),
        .line_o (line_o),
        .state_o(state_o),
        .ovf_o  (ovf_o)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Model: frame position, and the pixels of each line of the current frame.
    int  m_state = 0;
    int  m_line = 0;
    int  m_cnt = 0;
    bit  m_vs = 0;
    bit  m_dv = 0;
    int  pix [NL][MAXW];
    int  len [NL];
    int  e_state = 0;
    int  e_col = 0;
    int  e_line = 0;
    int  e_v0 = 0;
    int  e_v1 = 0;
    int  e_v2 = 0;
    bit  e_dv = 0;
    bit  e_hs = 0;
    bit  e_vs = 0;
    bit  e_ovf = 0;
    bit  c0 = 0;
    bit  c1 = 0;
    bit  c2 = 0;
    bit  cmp_on = 0;
    bit  fs_m;
    bit  le_m;
    bit  ov_m;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state = 0; m_line = 0; m_cnt = 0; m_vs = 0; m_dv = 0;
            e_state = 0; e_col = 0; e_line = 0; e_dv = 0; e_hs = 0;
            e_vs = 0; e_ovf = 0; e_v0 = 0; e_v1 = 0; e_v2 = 0;
            c0 = 1; c1 = 1; c2 = 1;
            for (int i = 0; i < NL; i++) len[i] = 0;
        end else begin
            fs_m = vs_i && !m_vs;
            le_m = !dv_i && m_dv;
            c0 = 0; c1 = 0; c2 = 0;
            if (fs_m) begin
                m_state = en_i ? 1 : 0;
                m_line = 0; m_cnt = 0;
                e_ovf = 0; e_col = 0; e_line = 0;
                for (int i = 0; i < NL; i++) len[i] = 0;
            end else if (le_m) begin
                if (m_state == 1 && m_line == 1) m_state = 2;
                if (m_line < LMAX) m_line++;
                m_cnt = 0;
            end
            if (dv_i) begin
                ov_m = (m_cnt >= MAXW);
                e_col = ov_m ? MAXW - 1 : m_cnt;
                e_line = m_line;
                if (ov_m) begin
                    e_ovf = 1;
                end else begin
                    c0 = 1; e_v0 = px_i;
                    if (m_line >= 1 && m_line < NL && m_cnt < len[m_line-1]) begin
                        c1 = 1; e_v1 = pix[m_line-1][m_cnt];
                    end
                    if (m_line >= 2 && m_line < NL && m_cnt < len[m_line-2]) begin
                        c2 = 1; e_v2 = pix[m_line-2][m_cnt];
                    end
                    if (m_line < NL) begin
                        pix[m_line][m_cnt] = px_i;
                        len[m_line] = m_cnt + 1;
                    end
                end
                m_cnt++;
            end
            e_dv = dv_i && (m_state == 2);
            e_hs = hs_i;
            e_vs = vs_i;
            e_state = m_state;
            m_vs = vs_i;
            m_dv = dv_i;
        end
    end

    // Single compare point, away from the active edge.
    always @(negedge clk) begin
        if (cmp_on) begin
            chk("state_o", state_o, e_state);
            chk("dv_o", dv_o, e_dv);
            chk("hs_o", hs_o, e_hs);
            chk("vs_o", vs_o, e_vs);
            chk("col_o", col_o, e_col);
            chk("line_o", line_o, e_line);
            chk("ovf_o", ovf_o, e_ovf);
            if (c0) chk("vect0", vect_o[0], e_v0);
            if (c1) chk("vect1", vect_o[1], e_v1);
            if (c2) chk("vect2", vect_o[2], e_v2);
        end
    end

    task automatic hook(input int mode, input int l, input int c);
        case (mode)
            1: begin
                if (l < 2) chk("prime_dv", dv_o, 0);
                if (l == 2 && c == 3) begin
                    chk("t2_vect", vect_o, 24'h031323);
                    chk("t2_dv", dv_o, 1);
                    chk("t2_state", state_o, 2);
                end
                if (l == 4 && c == 5) chk("t3_vect", vect_o, 24'h253545);
            end
            2: begin
                if (c == 15) begin
                    chk("t5_col15", col_o, 15);
                    chk("t5_noovf", ovf_o, 0);
                end
                if (c >= 16) begin
                    chk("t5_ovf", ovf_o, 1);
                    chk("t5_colhold", col_o, 15);
                end
            end
            3: begin
                chk("t6_prime_dv", dv_o, 0);
                chk("t6_prime_st", state_o, 1);
            end
            4: begin
                chk("t6_idle_st", state_o, 0);
                chk("t6_idle_dv", dv_o, 0);
            end
            default: ;
        endcase
    endtask

    task automatic drive(input bit dv, input int px, input bit hs, input bit vs);
        @(posedge clk);
        #1;
        dv_i = dv;
        px_i = CD'(px);
        hs_i = hs;
        vs_i = vs;
    endtask

    task automatic fstart(input bit en, input bit dv);
        @(posedge clk);
        #1;
        en_i = en;
        dv_i = dv;
        px_i = CD'($urandom_range(255));
        hs_i = 1'b0;
        vs_i = 1'b1;
    endtask

    task automatic send_line(input int l, input int n, input int blank,
                             input int mode, input bit pat);
        for (int c = 0; c < n; c++) begin
            drive(1'b1, pat ? 16 * l + c : int'($urandom_range(255)),
                  1'($urandom_range(1)), 1'b0);
            @(negedge clk);
            if (c >= 1) hook(mode, l, c - 1);
        end
        for (int b = 0; b < blank; b++) begin
            drive(1'b0, 0, 1'($urandom_range(1)), 1'b0);
            if (b == 0) begin
                @(negedge clk);
                hook(mode, l, n - 1);
            end
        end
    endtask

    initial begin
        int nl;
        int n;
        bit en;
        #1 rst = 1'b1;
        #1 cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // priming and ping-pong with px = 16*line + col
        fstart(1'b1, 1'b0);
        for (int l = 0; l < 5; l++) send_line(l, 8, 3, 1, 1'b1);

        // reset in the middle of a running line
        for (int c = 0; c < 3; c++) drive(1'b1, c, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b1; dv_i = 1'b0; hs_i = 1'b0; vs_i = 1'b0;
        @(negedge clk);
        chk("rst_state", state_o, 0);
        chk("rst_dv", dv_o, 0);
        chk("rst_vect", vect_o, 0);
        chk("rst_col", col_o, 0);
        chk("rst_line", line_o, 0);
        chk("rst_ovf", ovf_o, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int l = 0; l < 2; l++) send_line(l, 6, 2, 4, 1'b0);
        fstart(1'b0, 1'b0);
        send_line(0, 6, 2, 4, 1'b0);
        fstart(1'b1, 1'b0);
        send_line(0, 8, 2, 3, 1'b0);
        send_line(1, 8, 2, 3, 1'b0);
        send_line(2, 8, 2, 0, 1'b0);

        // single-cycle dv/hs/vs pulses in RUN
        drive(1'b0, 0, 1'b0, 1'b0);
        drive(1'b1, 8'h5a, 1'b1, 1'b0);
        @(negedge clk);
        chk("t4_dv_pre", dv_o, 0);
        chk("t4_hs_pre", hs_o, 0);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_dv", dv_o, 1);
        chk("t4_hs", hs_o, 1);
        chk("t4_px", vect_o[0], 8'h5a);
        drive(1'b0, 0, 1'b0, 1'b1);
        @(negedge clk);
        chk("t4_dv_post", dv_o, 0);
        chk("t4_vs_pre", vs_o, 0);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t4_vs", vs_o, 1);
        chk("t4_restart", state_o, 1);

        // frame restart mid-line, enabled then disabled
        for (int l = 0; l < 3; l++) send_line(l, 8, 2, 0, 1'b0);
        send_line(3, 4, 0, 0, 1'b0);
        fstart(1'b1, 1'b1);
        drive(1'b1, 7, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_state", state_o, 1);
        chk("t6_line", line_o, 0);
        chk("t6_col", col_o, 0);
        chk("t6_dv", dv_o, 0);
        send_line(0, 6, 2, 3, 1'b0);
        send_line(1, 8, 2, 3, 1'b0);
        send_line(2, 8, 2, 0, 1'b0);
        send_line(3, 4, 0, 0, 1'b0);
        fstart(1'b0, 1'b1);
        drive(1'b1, 9, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_idle", state_o, 0);
        send_line(0, 6, 2, 4, 1'b0);
        send_line(1, 6, 2, 4, 1'b0);
        send_line(2, 6, 2, 4, 1'b0);
        fstart(1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t6_reprime", state_o, 1);

        // overflow: 20 pixels into a 16-entry line RAM
        send_line(0, 20, 2, 2, 1'b0);
        send_line(1, 16, 2, 0, 1'b0);
        send_line(2, 16, 2, 0, 1'b0);
        fstart(1'b1, 1'b0);
        drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        chk("t5_ovf_clr", ovf_o, 0);

        // random frames
        for (int f = 0; f < 40; f++) begin
            en = ($urandom_range(3) != 0);
            fstart(en, ($urandom_range(3) == 0));
            nl = $urandom_range(6, 2);
            for (int l = 0; l < nl; l++) begin
                n = ($urandom_range(9) == 0) ? int'($urandom_range(20, 17))
                                             : int'($urandom_range(16, 1));
                if (l > 0 && $urandom_range(9) == 0) begin
                    send_line(l, (n > 1) ? n / 2 : 1, 0, 0, 1'b0);
                    break;
                end
                send_line(l, n, $urandom_range(3), 0, 1'b0);
            end
        end
        repeat (4) drive(1'b0, 0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
